// File: rtl/id_issue_queue.sv
// Circular multi-lane instruction queue between decode and register-read/issue.
// Accepts up to LANES in-order instructions per cycle and exposes the oldest LANES for partial issue.
module id_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 160,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int NUM_W     = $clog2(LANES + 1)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         flush,
    input  logic                         id_readygo,
    input  logic [LANES-1:0]             id_mask,
    input  logic [LANES*PAYLOAD_W-1:0]   id_payload,
    output logic                         id_allowin,
    output logic [LANES-1:0]             iq_valid,
    output logic [LANES*PAYLOAD_W-1:0]   iq_payload,
    input  logic [NUM_W-1:0]             reg_deq_num,
    output logic [CNT_W-1:0]             iq_count,
    output logic                         iq_overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PAYLOAD_W-1:0] wr_data [DEPTH];
    logic [DEPTH-1:0]     wr_en;
    logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 enq_fire, run;
    logic [CNT_W-1:0]     n_enq, n_deq, deq_req, deq_lim;

    // Only the contiguous run of valid lanes starting at lane 0 is accepted.
    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run = run & id_mask[i];
            if (run) n_enq = n_enq + CNT_W'(1);
        end
    end

    // allowin looks only at registered occupancy, keeping reg_deq_num off this path.
    assign id_allowin = (count_q <= CNT_W'(DEPTH - LANES));
    assign enq_fire   = id_readygo & id_allowin & ~flush;
    assign deq_req    = CNT_W'(reg_deq_num);
    assign deq_lim    = (count_q < CNT_W'(LANES)) ? count_q : CNT_W'(LANES);
    assign n_deq      = (deq_req < deq_lim) ? deq_req : deq_lim;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            overflow_d = overflow_q | (id_readygo & ~id_allowin & (|id_mask));
            head_d     = head_q + PTR_W'(n_deq);
            if (enq_fire) tail_d = tail_q + PTR_W'(n_enq);
            count_d    = count_q + (enq_fire ? n_enq : '0) - n_deq;
        end
    end

    // Each array slot picks whichever accepted lane lands on it this cycle.
    always_comb begin
        wr_en = '0;
        for (int e = 0; e < DEPTH; e++) begin
            wr_data[e] = '0;
            for (int i = 0; i < LANES; i++) begin
                if (enq_fire && (CNT_W'(i) < n_enq) && ((tail_q + PTR_W'(i)) == PTR_W'(e))) begin
                    wr_en[e]   = 1'b1;
                    wr_data[e] = id_payload[i*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_en[e]) mem_q[e] <= wr_data[e];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        iq_valid   = '0;
        iq_payload = '0;
        for (int i = 0; i < LANES; i++) begin
            if (count_q > CNT_W'(i)) begin
                iq_valid[i] = 1'b1;
                iq_payload[i*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PTR_W'(i)];
            end
        end
    end

    assign iq_count    = count_q;
    assign iq_overflow = overflow_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Self-checking bench for id_issue_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_id_issue_queue;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int PW    = 160;
    localparam int CNT_W = 4;
    localparam int NUM_W = 2;

    logic                  aclk = 1'b0;
    logic                  aresetn;
    logic                  flush;
    logic                  id_readygo;
    logic [LANES-1:0]      id_mask;
    logic [LANES*PW-1:0]   id_payload;
    logic                  id_allowin;
    logic [LANES-1:0]      iq_valid;
    logic [LANES*PW-1:0]   iq_payload;
    logic [NUM_W-1:0]      reg_deq_num;
    logic [CNT_W-1:0]      iq_count;
    logic                  iq_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [PW-1:0]       model_q[$];
    bit                  model_ovf;
    int                  exp_count;
    logic [LANES-1:0]    exp_valid;
    logic [LANES*PW-1:0] exp_pay;
    logic                exp_allow;
    logic                exp_ovf;

    id_issue_queue #(.DEPTH(DEPTH), .LANES(LANES), .PAYLOAD_W(PW)) dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .id_readygo(id_readygo),
        .id_mask(id_mask), .id_payload(id_payload), .id_allowin(id_allowin),
        .iq_valid(iq_valid), .iq_payload(iq_payload), .reg_deq_num(reg_deq_num),
        .iq_count(iq_count), .iq_overflow(iq_overflow)
    );

    always #5 aclk = ~aclk;

    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        return {$urandom(), $urandom(), $urandom(), $urandom(), pc};
    endfunction

    // Reference: a plain FIFO of payloads; dequeue takes from the front, enqueue appends.
    function automatic void model_edge();
        bit room_ok;
        int nd;
        room_ok = (DEPTH - model_q.size()) >= LANES;
        if (flush) begin
            model_q.delete();
        end else begin
            if (id_readygo && !room_ok && id_mask != 0) model_ovf = 1'b1;
            nd = int'(reg_deq_num);
            if (nd > LANES) nd = LANES;
            if (nd > model_q.size()) nd = model_q.size();
            repeat (nd) void'(model_q.pop_front());
            if (id_readygo && room_ok) begin
                for (int i = 0; i < LANES; i++) begin
                    if (!id_mask[i]) break;
                    model_q.push_back(id_payload[i*PW +: PW]);
                end
            end
        end
    endfunction

    function automatic void model_expect();
        exp_count = model_q.size();
        exp_valid = '0;
        exp_pay   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < model_q.size()) begin
                exp_valid[i] = 1'b1;
                exp_pay[i*PW +: PW] = model_q[i];
            end
        end
        exp_allow = (DEPTH - model_q.size()) >= LANES;
        exp_ovf   = model_ovf;
    endfunction

    task automatic set_in(input logic rg, input logic [1:0] m, input logic [PW-1:0] p0,
                          input logic [PW-1:0] p1, input logic [1:0] d, input logic f);
        id_readygo  = rg;
        id_mask     = m;
        id_payload  = {p1, p0};
        reg_deq_num = d;
        flush       = f;
    endtask

    task automatic idle();
        set_in(1'b0, 2'b00, '0, '0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge aclk);
        model_edge();
        #1;
        model_expect();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        idle();
        model_q.delete();
        model_ovf = 1'b0;
        #3;
        vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d exp 0", iq_count); end
        vectors++; if (iq_valid !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_valid got %b exp 00", iq_valid); end
        vectors++; if (iq_payload !== '0) begin miscompares++; $display("[TB] FAIL reset_payload got nonzero exp 0"); end
        vectors++; if (id_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_allowin got %b exp 1", id_allowin); end
        vectors++; if (iq_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got %b exp 0", iq_overflow); end
        #4;
        aresetn = 1'b1;
    endtask

    task automatic test_fill_issue();
        set_in(1'b1, 2'b11, mk(32'h00), mk(32'h04), 2'd0, 1'b0); tick();
        vectors++; if (iq_count !== 4'd2) begin miscompares++; $display("[TB] FAIL fill_latency_count got %0d exp 2", iq_count); end
        set_in(1'b1, 2'b11, mk(32'h08), mk(32'h0C), 2'd0, 1'b0); tick();
        idle();
        vectors++; if (iq_count !== 4'd4) begin miscompares++; $display("[TB] FAIL fill_count got %0d exp 4", iq_count); end
        vectors++; if (iq_valid !== 2'b11) begin miscompares++; $display("[TB] FAIL fill_valid got %b exp 11", iq_valid); end
        vectors++; if (iq_payload[31:0] !== 32'h00 || iq_payload[PW +: 32] !== 32'h04) begin
            miscompares++; $display("[TB] FAIL fill_pcs got %h/%h exp 0/4", iq_payload[31:0], iq_payload[PW +: 32]); end
        vectors++; if (iq_payload !== exp_pay) begin miscompares++; $display("[TB] FAIL fill_payload got %h exp %h", iq_payload, exp_pay); end
        vectors++; if (id_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_allowin got %b exp 1", id_allowin); end
    endtask

    task automatic test_full_overflow();
        set_in(1'b1, 2'b11, mk(32'h10), mk(32'h14), 2'd0, 1'b0); tick();
        set_in(1'b1, 2'b11, mk(32'h18), mk(32'h1C), 2'd0, 1'b0); tick();
        vectors++; if (iq_count !== 4'd8) begin miscompares++; $display("[TB] FAIL full_count got %0d exp 8", iq_count); end
        vectors++; if (id_allowin !== 1'b0) begin miscompares++; $display("[TB] FAIL full_allowin got %b exp 0", id_allowin); end
        vectors++; if (iq_overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL full_overflow_early got %b exp 0", iq_overflow); end
        set_in(1'b1, 2'b11, mk(32'h99), mk(32'h98), 2'd0, 1'b0); tick();
        idle();
        vectors++; if (iq_count !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_count got %0d exp 8", iq_count); end
        vectors++; if (iq_overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got %b exp 1", iq_overflow); end
        vectors++; if (iq_payload[31:0] !== 32'h00) begin miscompares++; $display("[TB] FAIL ovf_head got %h exp 0", iq_payload[31:0]); end
    endtask

    task automatic test_partial_issue();
        set_in(1'b0, 2'b00, '0, '0, 2'd2, 1'b0); tick(); tick();
        set_in(1'b0, 2'b00, '0, '0, 2'd1, 1'b0); tick();
        vectors++; if (iq_count !== 4'd3) begin miscompares++; $display("[TB] FAIL partial_setup_count got %0d exp 3", iq_count); end
        tick();
        vectors++; if (iq_count !== 4'd2) begin miscompares++; $display("[TB] FAIL partial_count got %0d exp 2", iq_count); end
        vectors++; if (iq_payload[31:0] !== 32'h18 || iq_payload[PW +: 32] !== 32'h1C) begin
            miscompares++; $display("[TB] FAIL partial_pcs got %h/%h exp 18/1c", iq_payload[31:0], iq_payload[PW +: 32]); end
        set_in(1'b1, 2'b01, mk(32'h20), mk(32'hEE), 2'd2, 1'b0); tick();
        idle();
        vectors++; if (iq_count !== 4'd1) begin miscompares++; $display("[TB] FAIL partial_enq_count got %0d exp 1", iq_count); end
        vectors++; if (iq_valid !== 2'b01 || iq_payload !== exp_pay) begin
            miscompares++; $display("[TB] FAIL partial_enq_lane got valid %b pc %h exp valid 01 pc 20", iq_valid, iq_payload[31:0]); end
    endtask

    task automatic test_wrap_clamp();
        set_in(1'b0, 2'b00, '0, '0, 2'd1, 1'b0); tick();
        for (int g = 0; g < 3; g++) begin
            set_in(1'b1, 2'b11, mk(32'h30 + 8*g), mk(32'h34 + 8*g), 2'd0, 1'b0); tick();
        end
        set_in(1'b0, 2'b00, '0, '0, 2'd2, 1'b0); tick(); tick(); tick();
        vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("[TB] FAIL wrap_drain got %0d exp 0", iq_count); end
        set_in(1'b1, 2'b11, mk(32'h40), mk(32'h44), 2'd0, 1'b0); tick();
        set_in(1'b1, 2'b11, mk(32'h48), mk(32'h4C), 2'd0, 1'b0); tick();
        vectors++; if (iq_payload[31:0] !== 32'h40 || iq_payload[PW +: 32] !== 32'h44 || iq_payload !== exp_pay) begin
            miscompares++; $display("[TB] FAIL wrap_read got %h/%h exp 40/44", iq_payload[31:0], iq_payload[PW +: 32]); end
        set_in(1'b0, 2'b00, '0, '0, 2'd2, 1'b0); tick();
        vectors++; if (iq_payload[31:0] !== 32'h48 || iq_payload[PW +: 32] !== 32'h4C || iq_payload !== exp_pay) begin
            miscompares++; $display("[TB] FAIL wrap_order got %h/%h exp 48/4c", iq_payload[31:0], iq_payload[PW +: 32]); end
        set_in(1'b0, 2'b00, '0, '0, 2'd1, 1'b0); tick();
        set_in(1'b0, 2'b00, '0, '0, 2'd2, 1'b0); tick();
        idle();
        vectors++; if (iq_count !== 4'd0 || iq_valid !== 2'b00) begin
            miscompares++; $display("[TB] FAIL clamp_count got %0d valid %b exp 0 valid 00", iq_count, iq_valid); end
    endtask

    task automatic test_flush();
        set_in(1'b1, 2'b11, mk(32'h50), mk(32'h54), 2'd0, 1'b0); tick(); tick();
        set_in(1'b1, 2'b01, mk(32'h58), mk(32'h5C), 2'd0, 1'b0); tick();
        vectors++; if (iq_count !== 4'd5) begin miscompares++; $display("[TB] FAIL flush_setup got %0d exp 5", iq_count); end
        set_in(1'b1, 2'b11, mk(32'h60), mk(32'h64), 2'd2, 1'b1); tick();
        idle();
        vectors++; if (iq_count !== 4'd0 || iq_valid !== 2'b00) begin
            miscompares++; $display("[TB] FAIL flush_clear got count %0d valid %b exp 0 00", iq_count, iq_valid); end
        vectors++; if (id_allowin !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_allowin got %b exp 1", id_allowin); end
        vectors++; if (iq_overflow !== exp_ovf) begin miscompares++; $display("[TB] FAIL flush_overflow got %b exp %b", iq_overflow, exp_ovf); end
        tick();
        vectors++; if (iq_count !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_nowrite got %0d exp 0", iq_count); end
    endtask

    task automatic test_mask();
        set_in(1'b1, 2'b11, mk(32'h70), mk(32'h74), 2'd0, 1'b0); tick();
        set_in(1'b1, 2'b10, mk(32'h78), mk(32'h7C), 2'd0, 1'b0); tick();
        vectors++; if (iq_count !== 4'd2) begin miscompares++; $display("[TB] FAIL mask_10 got %0d exp 2", iq_count); end
        set_in(1'b1, 2'b00, mk(32'h80), mk(32'h84), 2'd0, 1'b0); tick();
        idle();
        vectors++; if (iq_count !== 4'd2 || iq_payload !== exp_pay) begin
            miscompares++; $display("[TB] FAIL mask_00 got %0d exp 2", iq_count); end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 2'b11, mk(32'h90), mk(32'h94), 2'd0, 1'b0); tick(); tick();
        idle();
        vectors++; if (iq_count !== 4'd6) begin miscompares++; $display("[TB] FAIL areset_setup got %0d exp 6", iq_count); end
        #3;
        aresetn = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        vectors++; if (iq_count !== 4'd0 || iq_valid !== 2'b00) begin
            miscompares++; $display("[TB] FAIL areset_clear got count %0d valid %b exp 0 00", iq_count, iq_valid); end
        vectors++; if (iq_payload !== '0 || id_allowin !== 1'b1 || iq_overflow !== 1'b0) begin
            miscompares++; $display("[TB] FAIL areset_outputs got allowin %b ovf %b exp 1 0", id_allowin, iq_overflow); end
        #2;
        aresetn = 1'b1;
        model_expect();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), mk($urandom()), mk($urandom()),
                   2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
            tick();
            vectors++; if (iq_count !== CNT_W'(exp_count)) begin
                miscompares++; $display("[TB] FAIL rand_count cyc %0d got %0d exp %0d", c, iq_count, exp_count); end
            vectors++; if (iq_valid !== exp_valid) begin
                miscompares++; $display("[TB] FAIL rand_valid cyc %0d got %b exp %b", c, iq_valid, exp_valid); end
            vectors++; if (iq_payload !== exp_pay) begin
                miscompares++; $display("[TB] FAIL rand_payload cyc %0d got %h exp %h", c, iq_payload, exp_pay); end
            vectors++; if (id_allowin !== exp_allow || iq_overflow !== exp_ovf) begin
                miscompares++; $display("[TB] FAIL rand_flags cyc %0d got allowin %b ovf %b exp %b %b",
                                        c, id_allowin, iq_overflow, exp_allow, exp_ovf); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_issue();
        test_full_overflow();
        test_partial_issue();
        test_wrap_clamp();
        test_flush();
        test_mask();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised successor to the decode→register-read pipeline latch: a circular multi-lane instruction queue between ID and the register-read/issue stage.
- Accepts up to LANES decoded instructions per cycle and presents the oldest LANES entries in program order.
- Lets the consumer retire 0..LANES of them per cycle, so partial issue (e.g. only lane 0 issues) no longer stalls the whole group.
- Supports whole-queue flush on redirect/exception.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2*LANES.
- LANES, 2, enqueue and dequeue width; 1..4.
- PAYLOAD_W, 160, bits per instruction payload (pc, inst, uop, imm, regs, excp fields, packed by the parent).
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter.
- NUM_W, $clog2(LANES+1), width of the dequeue-count port.

Ports:
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  discard all contents; takes effect at the next edge.
- id_readygo  in  1  producer presents a group this cycle.
- id_mask  in  LANES  per-lane valid bits of the presented group; lane 0 is oldest.
- id_payload  in  LANES*PAYLOAD_W  lane i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- id_allowin  out  1  queue can accept a full group.
- iq_valid  out  LANES  lane i holds the i-th oldest entry.
- iq_payload  out  LANES*PAYLOAD_W  oldest entries, same lane packing as id_payload.
- reg_deq_num  in  NUM_W  number of entries the consumer takes this cycle, counted from lane 0.
- iq_count  out  CNT_W  current occupancy.
- iq_overflow  out  1  sticky error flag.

Behaviour:
- **State:** storage array, head pointer, tail pointer, count. Pointers wrap modulo DEPTH.
- **Reset** (async, aresetn=0):
  - head=tail=count=0; iq_overflow=0.
  - Outputs: iq_valid=0, iq_payload=0, id_allowin=1, iq_count=0.
  - Storage contents are don't-care.
- **id_allowin:** = (DEPTH − count ≥ LANES), computed from registered count only. Space freed by a same-cycle dequeue is not counted, so there is no combinational path from reg_deq_num to id_allowin.
- **Enqueue:** fires when id_readygo & id_allowin & ~flush.
  - n_enq = number of contiguous 1s in id_mask starting at lane 0. Lanes above the first 0 are ignored.
  - Accepted lanes are written to tail, tail+1, … in lane order. tail advances by n_enq.
  - id_mask=0 with id_readygo=1 enqueues nothing.
- **Dequeue:** n_deq = min(reg_deq_num, number of valid lanes). head advances by n_deq at the edge.
  - Outputs are combinational reads of storage at head+i.
  - iq_valid[i] = (count > i). Invalid lanes drive payload 0.
- **Latency:** an entry enqueued at edge k is visible on iq_* during cycle k+1. There is no same-cycle bypass, including when the queue is empty.
- **Simultaneous enqueue/dequeue:** count_next = count + n_enq − n_deq. This is legal at full and empty boundaries. Dequeue from a full queue with concurrent enqueue is impossible because id_allowin=0.
- **Flush:** highest priority below reset. At the edge: head=tail=count=0; same-cycle enqueue and dequeue are dropped; iq_overflow is unchanged. One cycle later iq_valid=0 and id_allowin=1.
- **Wrap-around:** a group that straddles DEPTH−1 → 0 is stored and read in order. iq_payload lanes may come from both ends of the array.
- **Overflow:** iq_overflow sets and holds (until reset) if an enqueue is ever attempted while id_allowin=0 and id_readygo=1 with id_mask≠0. The queue state is unaffected. This is an assertion aid only.
- iq_count reflects registered count.

Test Plan:
- **Fill and issue:** Reset, DEPTH=8, LANES=2. Enqueue mask 2'b11 with pc 0x00,0x04, then 0x08,0x0C, with reg_deq_num=0 → after 2 edges iq_count=4, iq_valid=2'b11, lanes show 0x00/0x04, id_allowin=1.
- **Reach full:** Continue enqueueing 2'b11 groups until iq_count=8 → id_allowin=0. A further id_readygo=1 leaves count at 8 and sets iq_overflow=1.
- **Partial issue:** Queue holds A,B,C (count=3); reg_deq_num=1 → next cycle lanes show B,C and count=2. Then reg_deq_num=2 with simultaneous enqueue of mask 2'b01 (D) → next cycle count=1 and lane 0 shows D.
- **Wrap and clamp:** Drive head to 7 and enqueue two groups across the wrap boundary → order preserved across index 7→0. Set reg_deq_num=2 while count=1 → n_deq=1 and count=0 (no underflow).
- **Flush:** Count=5; assert flush together with id_readygo=1, mask 2'b11 and reg_deq_num=2 → next cycle count=0, iq_valid=0, id_allowin=1, no entry written.
- **Async reset and mask handling:** Deassert aresetn mid-cycle with count=6 → outputs clear immediately without waiting for a clock edge. Separately, enqueue mask 2'b10 → nothing enqueued and count is unchanged.
